// File: rtl/cpu_mem_arb_pkg.sv
// Shared constants for the CPU memory arbiter: FSM states, owner codes,
// last-grant history and the latched memory command record.
package cpu_mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    RESP = 2'b10
  } arb_state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_e;

  typedef enum logic [1:0] {
    LAST_NONE = 2'b00,
    LAST_IF   = 2'b01,
    LAST_DM   = 2'b10
  } last_grant_e;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
  } mem_cmd_t;

  localparam logic [3:0] FETCH_BE = 4'hF;

  // A lone requester wins; on contention the side that did not win last time
  // goes next, and data wins when there is no history.
  function automatic owner_e pick_owner(input logic        if_req,
                                        input logic        dm_req,
                                        input last_grant_e last_grant);
    if (if_req && !dm_req) return OWN_IF;
    if (dm_req && !if_req) return OWN_DM;
    return (last_grant == LAST_DM) ? OWN_IF : OWN_DM;
  endfunction

endpackage

// File: rtl/cpu_mem_arb_if.sv
// Bundle of fetch, data and shared-memory signals around the arbiter.
// slave = arbiter side, master = CPU/memory side.
interface cpu_mem_arb_if;

  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        dm_req;
  logic        dm_we;
  logic [3:0]  dm_be;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;

  logic        stall_n;
  logic        bus_err;

  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           mem_rdata, mem_ack,
    output if_rdata, if_ack, dm_rdata, dm_ack,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall_n, bus_err
  );

  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_be, dm_addr, dm_wdata,
           mem_rdata, mem_ack,
    input  if_rdata, if_ack, dm_rdata, dm_ack,
           mem_req, mem_we, mem_be, mem_addr, mem_wdata, stall_n, bus_err
  );

endinterface

// File: rtl/cpu_arb_wdog.sv
// Saturating 8-bit wait counter; flags expiry on the BUSY cycle in which the
// count would reach TIMEOUT without a memory acknowledge.
module cpu_arb_wdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic i_busy,
  input  logic i_ack,
  output logic o_expire
);

  localparam logic [7:0] LIMIT = 8'(TIMEOUT - 1);

  logic [7:0] r_cnt;

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values; blocking here would create simulation/synthesis races.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (!i_busy || i_ack) begin
      r_cnt <= '0;
    end else if (r_cnt != 8'hFF) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign o_expire = i_busy & ~i_ack & (r_cnt >= LIMIT);

endmodule

// File: rtl/cpu_mem_arb.sv
// Two-port (fetch/data) arbiter onto a single shared memory bus with
// alternating priority, one-cycle ack pulses and a timeout abort.
module cpu_mem_arb
  import cpu_mem_arb_pkg::*;
#(
  parameter int TIMEOUT = 255
) (
  input  logic           clk,
  input  logic           rst,
  cpu_mem_arb_if.slave   bus
);

  arb_state_e  r_state, w_next_state;
  owner_e      r_owner, w_grant;
  last_grant_e r_last;
  mem_cmd_t    r_cmd, w_req_cmd;
  logic        r_err;
  logic [31:0] r_if_rdata, r_dm_rdata;
  logic        w_any_req, w_busy, w_resp, w_expire;

  assign w_any_req = bus.if_req | bus.dm_req;
  assign w_busy    = (r_state == BUSY);
  assign w_resp    = (r_state == RESP);
  assign w_grant   = pick_owner(bus.if_req, bus.dm_req, r_last);

  always_comb begin
    w_req_cmd = '{we: 1'b0, be: FETCH_BE, addr: bus.if_addr, wdata: 32'h0};
    if (w_grant == OWN_DM) begin
      w_req_cmd = '{we: bus.dm_we, be: bus.dm_be, addr: bus.dm_addr, wdata: bus.dm_wdata};
    end
  end

  cpu_arb_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .i_busy   (w_busy),
    .i_ack    (bus.mem_ack),
    .o_expire (w_expire)
  );

  // NOTE: the default assignment first keeps every path driven, so no latch
  // is inferred when a case arm leaves the state unchanged.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE:    if (w_any_req) w_next_state = BUSY;
      BUSY:    if (bus.mem_ack || w_expire) w_next_state = RESP;
      RESP:    w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next_state;
  end

  // NOTE: all datapath registers are reset, not just control, because the
  // rdata holding registers are architecturally visible right after reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner    <= OWN_DM;
      r_last     <= LAST_NONE;
      r_cmd      <= '0;
      r_err      <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_req) begin
            r_owner <= w_grant;
            r_cmd   <= w_req_cmd;
            r_last  <= (w_grant == OWN_IF) ? LAST_IF : LAST_DM;
          end
        end
        BUSY: begin
          // A timeout returns zero data to the owner and flags the abort.
          if (bus.mem_ack || w_expire) begin
            r_err <= ~bus.mem_ack;
            if (r_owner == OWN_IF) r_if_rdata <= bus.mem_ack ? bus.mem_rdata : 32'h0;
            else                   r_dm_rdata <= bus.mem_ack ? bus.mem_rdata : 32'h0;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = w_busy;
  assign bus.mem_we    = w_busy & r_cmd.we;
  assign bus.mem_be    = w_busy ? r_cmd.be    : 4'h0;
  assign bus.mem_addr  = w_busy ? r_cmd.addr  : 32'h0;
  assign bus.mem_wdata = w_busy ? r_cmd.wdata : 32'h0;

  assign bus.if_ack   = w_resp & (r_owner == OWN_IF);
  assign bus.dm_ack   = w_resp & (r_owner == OWN_DM);
  assign bus.bus_err  = w_resp & r_err;
  assign bus.if_rdata = r_if_rdata;
  assign bus.dm_rdata = r_dm_rdata;

  assign bus.stall_n = ~((bus.if_req & ~bus.if_ack) | (bus.dm_req & ~bus.dm_ack));

endmodule

// File: tb/tb_cpu_mem_arb.sv
// Directed, table-driven bench for cpu_mem_arb (TIMEOUT=4) plus hand-written
// timeout-latency and asynchronous-reset sequences.
module tb_cpu_mem_arb;

  typedef enum logic [1:0] {B_NONE, B_IF, B_DMR, B_DMW} bus_exp_e;

  typedef struct {
    logic        rst;
    logic        if_req;
    logic        dm_req;
    logic        dm_we;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    bus_exp_e    e_bus;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic        e_bus_err;
    logic        e_stall_n;
    logic [31:0] e_if_rdata;
    logic [31:0] e_dm_rdata;
  } vec_t;

  localparam logic [31:0] IF_ADDR  = 32'h0000_0100;
  localparam logic [31:0] DM_ADDR  = 32'h0000_2000;
  localparam logic [31:0] DM_WDATA = 32'hDEAD_BEEF;
  localparam logic [3:0]  DM_BE    = 4'b0011;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  cpu_mem_arb_if bus();

  cpu_mem_arb #(.TIMEOUT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input logic rst_i, input logic ifr, input logic dmr, input logic we,
                     input logic ack, input logic [31:0] rdata, input bus_exp_e eb,
                     input logic eia, input logic eda, input logic eerr, input logic est,
                     input logic [31:0] eird, input logic [31:0] edrd);
    vec_t v;
    v.rst = rst_i; v.if_req = ifr; v.dm_req = dmr; v.dm_we = we;
    v.mem_ack = ack; v.mem_rdata = rdata; v.e_bus = eb;
    v.e_if_ack = eia; v.e_dm_ack = eda; v.e_bus_err = eerr; v.e_stall_n = est;
    v.e_if_rdata = eird; v.e_dm_rdata = edrd;
    vecs.push_back(v);
  endtask

  initial begin
    logic        e_req, e_we;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wdata;
    int          lat;

    rst = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = IF_ADDR;
    bus.dm_req = 1'b0; bus.dm_we = 1'b0; bus.dm_be = DM_BE;
    bus.dm_addr = DM_ADDR; bus.dm_wdata = DM_WDATA;
    bus.mem_ack = 1'b0; bus.mem_rdata = 32'h0;

    //  rst ifr dmr we ack rdata           bus     ia da er st  if_rdata      dm_rdata
    add(1, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h0,        32'h0);        // reset
    add(0, 1, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h0,        32'h0);        // solo fetch
    add(0, 1, 0, 0, 1, 32'h2402000A, B_IF,   0, 0, 0, 0, 32'h0,        32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        B_NONE, 1, 0, 0, 1, 32'h2402000A, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h2402000A, 32'h0);
    add(1, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h0,        32'h0);        // clear history
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h0,        32'h0);        // contention
    add(0, 1, 1, 0, 1, 32'h11111111, B_DMR,  0, 0, 0, 0, 32'h0,        32'h0);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 0, 1, 0, 0, 32'h0,        32'h11111111);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h0,        32'h11111111);
    add(0, 1, 1, 0, 1, 32'h22222222, B_IF,   0, 0, 0, 0, 32'h0,        32'h11111111);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 1, 0, 0, 0, 32'h22222222, 32'h11111111);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h22222222, 32'h11111111);
    add(0, 1, 1, 0, 1, 32'h33333333, B_DMR,  0, 0, 0, 0, 32'h22222222, 32'h11111111);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 0, 1, 0, 0, 32'h22222222, 32'h33333333);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h22222222, 32'h33333333);
    add(0, 1, 1, 0, 1, 32'h44444444, B_IF,   0, 0, 0, 0, 32'h22222222, 32'h33333333);
    add(0, 1, 1, 0, 0, 32'h0,        B_NONE, 1, 0, 0, 0, 32'h44444444, 32'h33333333);
    add(0, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h44444444, 32'h33333333);
    add(0, 0, 1, 1, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h44444444, 32'h33333333); // write
    add(0, 0, 1, 1, 0, 32'h0,        B_DMW,  0, 0, 0, 0, 32'h44444444, 32'h33333333);
    add(0, 0, 1, 1, 0, 32'h0,        B_DMW,  0, 0, 0, 0, 32'h44444444, 32'h33333333);
    add(0, 0, 1, 1, 1, 32'h55555555, B_DMW,  0, 0, 0, 0, 32'h44444444, 32'h33333333);
    add(0, 0, 1, 1, 0, 32'h0,        B_NONE, 0, 1, 0, 1, 32'h44444444, 32'h55555555);
    add(0, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h44444444, 32'h55555555);
    add(0, 0, 1, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h44444444, 32'h55555555); // timeout
    add(0, 0, 1, 0, 0, 32'h0,        B_DMR,  0, 0, 0, 0, 32'h44444444, 32'h55555555);
    add(0, 0, 1, 0, 0, 32'h0,        B_DMR,  0, 0, 0, 0, 32'h44444444, 32'h55555555);
    add(0, 0, 1, 0, 0, 32'h0,        B_DMR,  0, 0, 0, 0, 32'h44444444, 32'h55555555);
    add(0, 0, 1, 0, 0, 32'h0,        B_DMR,  0, 0, 0, 0, 32'h44444444, 32'h55555555);
    add(0, 0, 1, 0, 0, 32'h0,        B_NONE, 0, 1, 1, 1, 32'h44444444, 32'h0);
    add(0, 0, 0, 0, 1, 32'h77777777, B_NONE, 0, 0, 0, 1, 32'h44444444, 32'h0);        // stray ack
    add(0, 1, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h44444444, 32'h0);        // reset mid-BUSY
    add(1, 0, 0, 0, 1, 32'h88888888, B_NONE, 0, 0, 0, 1, 32'h0,        32'h0);
    add(0, 0, 0, 0, 1, 32'h88888888, B_NONE, 0, 0, 0, 1, 32'h0,        32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h0,        32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 0, 32'h0,        32'h0);
    add(0, 1, 0, 0, 1, 32'h66666666, B_IF,   0, 0, 0, 0, 32'h0,        32'h0);
    add(0, 1, 0, 0, 0, 32'h0,        B_NONE, 1, 0, 0, 1, 32'h66666666, 32'h0);
    add(0, 0, 0, 0, 0, 32'h0,        B_NONE, 0, 0, 0, 1, 32'h66666666, 32'h0);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      rst           = vecs[i].rst;
      bus.if_req    = vecs[i].if_req;
      bus.dm_req    = vecs[i].dm_req;
      bus.dm_we     = vecs[i].dm_we;
      bus.mem_ack   = vecs[i].mem_ack;
      bus.mem_rdata = vecs[i].mem_rdata;
      #3;
      e_req   = (vecs[i].e_bus != B_NONE);
      e_we    = (vecs[i].e_bus == B_DMW);
      e_be    = (vecs[i].e_bus == B_IF) ? 4'hF : (e_req ? DM_BE : 4'h0);
      e_addr  = (vecs[i].e_bus == B_IF) ? IF_ADDR : (e_req ? DM_ADDR : 32'h0);
      e_wdata = (vecs[i].e_bus == B_DMR || vecs[i].e_bus == B_DMW) ? DM_WDATA : 32'h0;
      check($sformatf("v%0d.mem_req", i),   32'(bus.mem_req),  32'(e_req));
      check($sformatf("v%0d.mem_we", i),    32'(bus.mem_we),   32'(e_we));
      check($sformatf("v%0d.mem_be", i),    32'(bus.mem_be),   32'(e_be));
      check($sformatf("v%0d.mem_addr", i),  bus.mem_addr,      e_addr);
      check($sformatf("v%0d.mem_wdata", i), bus.mem_wdata,     e_wdata);
      check($sformatf("v%0d.if_ack", i),    32'(bus.if_ack),   32'(vecs[i].e_if_ack));
      check($sformatf("v%0d.dm_ack", i),    32'(bus.dm_ack),   32'(vecs[i].e_dm_ack));
      check($sformatf("v%0d.bus_err", i),   32'(bus.bus_err),  32'(vecs[i].e_bus_err));
      check($sformatf("v%0d.stall_n", i),   32'(bus.stall_n),  32'(vecs[i].e_stall_n));
      check($sformatf("v%0d.if_rdata", i),  bus.if_rdata,      vecs[i].e_if_rdata);
      check($sformatf("v%0d.dm_rdata", i),  bus.dm_rdata,      vecs[i].e_dm_rdata);
    end

    // Timeout latency: request in IDLE, four BUSY cycles, ack in the fifth.
    @(posedge clk);
    #1 bus.dm_req = 1'b1; bus.dm_we = 1'b0; bus.mem_ack = 1'b0;
    lat = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge clk);
      #3;
      if (bus.dm_ack) begin
        lat = cyc;
        break;
      end
    end
    check("tmo.latency",  32'(lat),          32'd5);
    check("tmo.bus_err",  32'(bus.bus_err),  32'd1);
    check("tmo.dm_rdata", bus.dm_rdata,      32'h0);
    check("tmo.mem_req",  32'(bus.mem_req),  32'd0);
    bus.dm_req = 1'b0;

    // Reset asserted asynchronously in the middle of a BUSY cycle.
    @(posedge clk);
    #1 bus.if_req = 1'b1;
    @(posedge clk);
    #1;
    check("rstb.busy_req",  32'(bus.mem_req), 32'd1);
    check("rstb.busy_addr", bus.mem_addr,     IF_ADDR);
    bus.if_req = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rstb.mem_req",  32'(bus.mem_req), 32'd0);
    check("rstb.mem_addr", bus.mem_addr,     32'h0);
    check("rstb.mem_be",   32'(bus.mem_be),  32'd0);
    @(posedge clk);
    #1 rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 32'h99999999;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #3;
      check($sformatf("rstb.no_if_ack%0d", k), 32'(bus.if_ack),  32'd0);
      check($sformatf("rstb.no_req%0d", k),    32'(bus.mem_req), 32'd0);
      check($sformatf("rstb.if_rdata%0d", k),  bus.if_rdata,     32'h0);
    end
    bus.mem_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
